// File: rtl/sensor_inject_packer_pkg.sv
// Shared types and helpers for the sensor-inject packer: FSM encoding and
// width derivations used by the packer datapath.
package sensor_inject_packer_pkg;

  // FSM encoding shared by the sensor-inject blocks.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bytes (cells) per output word.
  function automatic int calc_bpw(input int out_width);
    return out_width / 8;
  endfunction

  // Words per frame.
  function automatic int calc_wpf(input int cells_per_frame, input int out_width);
    return cells_per_frame / (out_width / 8);
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sensor_inject_packer.sv
// Packs the 8-bit sensor-inject cell stream little-endian into OUT_WIDTH-bit
// words, flags the last word of each frame with TLAST and counts emitted
// frames. Start/stop requests from i_ENABLE only take effect on frame
// boundaries so downstream never sees a truncated frame.
module sensor_inject_packer
  import sensor_inject_packer_pkg::*;
#(
  parameter int OUT_WIDTH       = 512,
  parameter int CELLS_PER_FRAME = 2048
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_ENABLE,
  input  logic [7:0]           axis_vector_tdata,
  input  logic                 axis_vector_tvalid,
  output logic                 axis_vector_tready,
  output logic [OUT_WIDTH-1:0] axis_out_tdata,
  output logic                 axis_out_tvalid,
  output logic                 axis_out_tlast,
  input  logic                 axis_out_tready,
  output logic [31:0]          o_FRAME_COUNT,
  output logic                 o_BUSY
);

  localparam int BPW  = calc_bpw(OUT_WIDTH);
  localparam int IDXW = cnt_width(BPW);
  localparam int CNTW = cnt_width(CELLS_PER_FRAME);
  localparam int ACCW = OUT_WIDTH - 8;

  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(BPW - 1);
  localparam logic [CNTW-1:0] LAST_CELL = CNTW'(CELLS_PER_FRAME - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [IDXW-1:0]        r_byte_idx;
  logic [CNTW-1:0]        r_cell_cnt;
  logic [ACCW-1:0]        r_acc;
  logic [OUT_WIDTH-1:0]   r_out_data;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic [31:0]            r_frame_count;

  logic                   w_active;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_word_done;
  logic                   w_last_cell_acc;
  logic                   w_out_fire;

  // A disabled RUN state at a frame boundary must not start a new frame, so
  // input is only taken while a frame is in progress or still wanted.
  assign w_active = (r_state == ST_DRAIN) |
                    ((r_state == ST_RUN) & (i_ENABLE | (r_cell_cnt != '0)));

  // Only the word-completing cell needs room in the output register.
  assign w_in_ready      = w_active & ((r_byte_idx != LAST_IDX) | ~r_out_valid | axis_out_tready);
  assign w_accept        = axis_vector_tvalid & w_in_ready;
  assign w_word_done     = w_accept & (r_byte_idx == LAST_IDX);
  assign w_last_cell_acc = w_accept & (r_cell_cnt == LAST_CELL);
  assign w_out_fire      = r_out_valid & axis_out_tready;

  // Next-state logic: stop requests resolve only at frame boundaries.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_ENABLE) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_ENABLE) begin
          w_next_state = ST_RUN;
        end else if ((r_cell_cnt == '0) || w_last_cell_acc) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_ENABLE) begin
          w_next_state = ST_RUN;
        end else if (w_last_cell_acc) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Position of the next cell within its word and within its frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_idx <= '0;
      r_cell_cnt <= '0;
    end else if (w_accept) begin
      r_byte_idx <= (r_byte_idx == LAST_IDX)  ? '0 : r_byte_idx + 1'b1;
      r_cell_cnt <= (r_cell_cnt == LAST_CELL) ? '0 : r_cell_cnt + 1'b1;
    end
  end

  // Accumulator holds the lower cells of the word being assembled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < BPW - 1; k++) begin
        if (r_byte_idx == IDXW'(k)) begin
          r_acc[8*k +: 8] <= axis_vector_tdata;
        end
      end
    end
  end

  // Output register: load on the word's last cell, clear once drained;
  // a load in the drain cycle gives back-to-back words.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_word_done) begin
      r_out_data  <= {axis_vector_tdata, r_acc};
      r_out_valid <= 1'b1;
      r_out_last  <= (r_cell_cnt == LAST_CELL);
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // Frames are counted when their final word is taken downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_count <= 32'd0;
    end else if (w_out_fire && r_out_last) begin
      r_frame_count <= r_frame_count + 32'd1;
    end
  end

  assign axis_vector_tready = w_in_ready;
  assign axis_out_tdata     = r_out_data;
  assign axis_out_tvalid    = r_out_valid;
  assign axis_out_tlast     = r_out_last;
  assign o_FRAME_COUNT      = r_frame_count;
  assign o_BUSY             = (r_state != ST_IDLE);

endmodule
